// File: rtl/addsub_serial_pkg.sv
// Shared constants for the digit-serial adder/subtractor: FSM encodings and mode values.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package addsub_serial_pkg;

    // FSM encodings, kept as plain constants so older blocks can share them
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Operation select carried on the mode input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_xor_bank.sv
// Gate-level conditional inverter: y[i] = a[i] ^ b[i], one XOR per bit.
// Latency: combinational.
// Backpressure: none.
module xor_bank #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = a[i] ^ b[i];
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement a+b / a-b, DIGIT bits per clock, LSB digit first.
// Latency: WIDTH/DIGIT cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] b_cond;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sub_op;
    logic             last_dig;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;

    // Subtraction is a + ~b + 1: invert B here and seed the carry with 1
    assign sub_op = (mode == MODE_SUB);

    xor_bank #(
        .WIDTH(WIDTH)
    ) u_inv (
        .a(b),
        .b({WIDTH{sub_op}}),
        .y(b_cond)
    );

    assign last_dig = (cnt == CW'(NDIG - 1));
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // One DIGIT-wide ripple slice on the low digit of the shifting operands;
    // the carry into the top bit is recovered from the sum bit and its inputs
    always_comb begin
        dsum    = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        msb_cin = dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
    end

    // FSM, operand shift registers, digit counter and result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            y     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_cond;
                        carry <= sub_op;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    y[cnt*DIGIT +: DIGIT] <= dsum[DIGIT-1:0];
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last_dig) begin
                        cout  <= dsum[DIGIT];
                        ovf   <= dsum[DIGIT] ^ msb_cin;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
